fetch_ctrl: RTL and testbench

Run-control and program-counter stage feeding the instruction ROM of the 8-bit core. It waits for a start request and steps the program counter, handling absolute jumps (from the branch LUT), relative jumps and stalls. It stops at a fixed halt address and raises `done`, replacing the bare `prog_ctr == 128` comparison with a registered handshake. It also counts executed cycles for benchmarking.

---
 rtl/fetch_ctrl.sv | 120 ++++++++++++
 tb/tb_fetch_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: run-control FSM and program counter for the 8-bit core.
// It waits for a start request, steps the PC with stall/absolute/relative
// jump handling, and halts at END_ADDR with a registered done flag. It also
// keeps a saturating count of RUN cycles for benchmarking.
module fetch_ctrl #(
    parameter int D          = 12,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 128,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          absjump_en,
    input  logic          reljump_en,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    localparam logic [D-1:0]  START_PC = D'(START_ADDR);
    localparam logic [D-1:0]  END_PC   = D'(END_ADDR);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [D-1:0]  pc_r;
    logic [D-1:0]  pc_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          done_r;
    logic          at_end_s;
    logic          fetch_valid_s;

    assign at_end_s      = (pc_r == END_PC);
    assign fetch_valid_s = (state_r == ST_RUN) && !at_end_s;

    // Next-state, next-PC and next-count logic for the run-control FSM.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = START_PC;
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Every RUN cycle counts, including stalls and the halt cycle.
                if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CW'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (at_end_s) begin
                    // The halt address is never executed; PC parks on it.
                    state_nxt_s = ST_DONE;
                    pc_nxt_s    = pc_r;
                end else if (stall) begin
                    pc_nxt_s = pc_r;
                end else if (absjump_en) begin
                    pc_nxt_s = target;
                end else if (reljump_en) begin
                    // D-bit add is the two's complement offset, modulo 2^D.
                    pc_nxt_s = pc_r + target;
                end else begin
                    pc_nxt_s = pc_r + D'(1);
                end
            end
            ST_DONE: begin
                // Require req to drop before a new program may start.
                if (!req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = START_PC;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, PC, cycle counter and done registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            pc_r    <= START_PC;
            cnt_r   <= {CW{1'b0}};
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign prog_ctr    = pc_r;
    assign fetch_valid = fetch_valid_s;
    assign done        = done_r;
    assign cycle_cnt   = cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: default build plus a wrap-around build
// (START=FFE, END=2) and a START==END build, all sharing stimulus.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        stall = 1'b0;
    logic        absjump_en = 1'b0;
    logic        reljump_en = 1'b0;
    logic [11:0] target = 12'd0;

    logic [11:0] pc, pc_w, pc_e;
    logic        fv, fv_w, fv_e;
    logic        dn, dn_w, dn_e;
    logic [15:0] cnt, cnt_w, cnt_e;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl #(.D(12), .START_ADDR(0), .END_ADDR(128), .CW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
        .prog_ctr(pc), .fetch_valid(fv), .done(dn), .cycle_cnt(cnt)
    );

    fetch_ctrl #(.D(12), .START_ADDR(12'hFFE), .END_ADDR(2), .CW(16)) dut_w (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
        .prog_ctr(pc_w), .fetch_valid(fv_w), .done(dn_w), .cycle_cnt(cnt_w)
    );

    fetch_ctrl #(.D(12), .START_ADDR(5), .END_ADDR(5), .CW(16)) dut_e (
        .clk(clk), .reset(reset), .req(req), .stall(stall),
        .absjump_en(absjump_en), .reljump_en(reljump_en), .target(target),
        .prog_ctr(pc_e), .fetch_valid(fv_e), .done(dn_e), .cycle_cnt(cnt_e)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 1'b0; stall = 1'b0; absjump_en = 1'b0; reljump_en = 1'b0;
        target = 12'd0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 12'd0 || fv !== 1'b0 || dn !== 1'b0 || cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_values: pc=%0d fv=%0b done=%0b cnt=%0d, want 0/0/0/0", pc, fv, dn, cnt);
        end
        #2;
        reset = 1'b0;
        tick();
        n_cmp++;
        if (fv !== 1'b0 || dn !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: fv=%0b done=%0b, want 0/0", fv, dn);
        end
    endtask

    task automatic test_straight();
        int fv_cycles;
        fv_cycles = 0;
        do_reset();
        req = 1'b1;
        tick();
        for (int i = 0; i <= 128; i++) begin
            if (fv === 1'b1) fv_cycles++;
            n_cmp++;
            if (pc !== 12'(i) || cnt !== 16'(i) || fv !== (i != 128) || dn !== 1'b0) begin
                n_err++;
                $display("FAIL straight_step%0d: pc=%0d cnt=%0d fv=%0b done=%0b, want %0d/%0d/%0b/0",
                         i, pc, cnt, fv, dn, i, i, (i != 128));
            end
            tick();
        end
        n_cmp++;
        if (fv_cycles != 128) begin
            n_err++;
            $display("FAIL straight_fv_count: got %0d, want 128", fv_cycles);
        end
        n_cmp++;
        if (dn !== 1'b1 || pc !== 12'd128 || cnt !== 16'd129 || fv !== 1'b0) begin
            n_err++;
            $display("FAIL straight_done: done=%0b pc=%0d cnt=%0d fv=%0b, want 1/128/129/0", dn, pc, cnt, fv);
        end
    endtask

    task automatic test_handshake();
        // Continues from the DONE state of test_straight with req still high.
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (dn !== 1'b1 || pc !== 12'd128 || cnt !== 16'd129) begin
                n_err++;
                $display("FAIL done_hold%0d: done=%0b pc=%0d cnt=%0d, want 1/128/129", k, dn, pc, cnt);
            end
        end
        req = 1'b0;
        tick();
        n_cmp++;
        if (dn !== 1'b0 || fv !== 1'b0 || cnt !== 16'd129) begin
            n_err++;
            $display("FAIL back_to_idle: done=%0b fv=%0b cnt=%0d, want 0/0/129", dn, fv, cnt);
        end
        req = 1'b1;
        tick();
        n_cmp++;
        if (pc !== 12'd0 || fv !== 1'b1 || cnt !== 16'd0 || dn !== 1'b0) begin
            n_err++;
            $display("FAIL restart: pc=%0d fv=%0b cnt=%0d done=%0b, want 0/1/0/0", pc, fv, cnt, dn);
        end
    endtask

    task automatic test_jumps();
        do_reset();
        req = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (pc !== 12'd5) begin
            n_err++;
            $display("FAIL jmp_reach5: pc=%0d, want 5", pc);
        end
        absjump_en = 1'b1; target = 12'd40;
        tick();
        n_cmp++;
        if (pc !== 12'd40) begin
            n_err++;
            $display("FAIL absjump: pc=%0d, want 40", pc);
        end
        absjump_en = 1'b0; reljump_en = 1'b1; target = 12'hFFD;
        tick();
        n_cmp++;
        if (pc !== 12'd37) begin
            n_err++;
            $display("FAIL reljump_neg: pc=%0d, want 37", pc);
        end
        reljump_en = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 12'd38) begin
            n_err++;
            $display("FAIL after_rel: pc=%0d, want 38", pc);
        end
        absjump_en = 1'b1; target = 12'd10;
        tick();
        absjump_en = 1'b1; reljump_en = 1'b1; target = 12'd20;
        tick();
        n_cmp++;
        if (pc !== 12'd20) begin
            n_err++;
            $display("FAIL abs_over_rel: pc=%0d, want 20", pc);
        end
        absjump_en = 1'b0; reljump_en = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 12'd21) begin
            n_err++;
            $display("FAIL after_both: pc=%0d, want 21", pc);
        end
        absjump_en = 1'b1; target = 12'd128;
        tick();
        absjump_en = 1'b0;
        n_cmp++;
        if (pc !== 12'd128 || fv !== 1'b0 || dn !== 1'b0) begin
            n_err++;
            $display("FAIL jump_to_end: pc=%0d fv=%0b done=%0b, want 128/0/0", pc, fv, dn);
        end
        absjump_en = 1'b1; target = 12'd3;
        tick();
        n_cmp++;
        if (dn !== 1'b1 || pc !== 12'd128) begin
            n_err++;
            $display("FAIL jump_end_done: done=%0b pc=%0d, want 1/128", dn, pc);
        end
        tick();
        absjump_en = 1'b0;
        n_cmp++;
        if (pc !== 12'd128) begin
            n_err++;
            $display("FAIL done_ignores_jump: pc=%0d, want 128", pc);
        end
    endtask

    task automatic test_stall();
        do_reset();
        req = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) tick();
        n_cmp++;
        if (pc !== 12'd7 || cnt !== 16'd7) begin
            n_err++;
            $display("FAIL stall_reach7: pc=%0d cnt=%0d, want 7/7", pc, cnt);
        end
        stall = 1'b1; absjump_en = 1'b1; target = 12'd40;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (pc !== 12'd7 || cnt !== 16'(8 + k)) begin
                n_err++;
                $display("FAIL stall_hold%0d: pc=%0d cnt=%0d, want 7/%0d", k, pc, cnt, 8 + k);
            end
        end
        stall = 1'b0; absjump_en = 1'b0;
        tick();
        n_cmp++;
        if (pc !== 12'd8 || cnt !== 16'd11) begin
            n_err++;
            $display("FAIL stall_release: pc=%0d cnt=%0d, want 8/11", pc, cnt);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_pc [5];
        exp_pc[0] = 12'hFFE; exp_pc[1] = 12'hFFF; exp_pc[2] = 12'h000;
        exp_pc[3] = 12'h001; exp_pc[4] = 12'h002;
        do_reset();
        req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (pc_w !== exp_pc[k] || fv_w !== (k != 4) || dn_w !== 1'b0) begin
                n_err++;
                $display("FAIL wrap_step%0d: pc=%h fv=%0b done=%0b, want %h/%0b/0",
                         k, pc_w, fv_w, dn_w, exp_pc[k], (k != 4));
            end
        end
        tick();
        n_cmp++;
        if (dn_w !== 1'b1 || pc_w !== 12'h002 || cnt_w !== 16'd5) begin
            n_err++;
            $display("FAIL wrap_done: done=%0b pc=%h cnt=%0d, want 1/002/5", dn_w, pc_w, cnt_w);
        end
    endtask

    task automatic test_start_eq_end();
        do_reset();
        req = 1'b1;
        tick();
        n_cmp++;
        if (pc_e !== 12'd5 || fv_e !== 1'b0 || dn_e !== 1'b0 || cnt_e !== 16'd0) begin
            n_err++;
            $display("FAIL eq_run: pc=%0d fv=%0b done=%0b cnt=%0d, want 5/0/0/0", pc_e, fv_e, dn_e, cnt_e);
        end
        tick();
        n_cmp++;
        if (dn_e !== 1'b1 || cnt_e !== 16'd1) begin
            n_err++;
            $display("FAIL eq_done: done=%0b cnt=%0d, want 1/1", dn_e, cnt_e);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        req = 1'b1;
        tick();
        for (int k = 0; k < 50; k++) tick();
        n_cmp++;
        if (pc !== 12'd50 || fv !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reach50: pc=%0d fv=%0b, want 50/1", pc, fv);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pc !== 12'd0 || fv !== 1'b0 || dn !== 1'b0 || cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset_values: pc=%0d fv=%0b done=%0b cnt=%0d, want 0/0/0/0", pc, fv, dn, cnt);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (fv !== 1'b0 || pc !== 12'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: fv=%0b pc=%0d, want 0/0", fv, pc);
        end
        tick();
        n_cmp++;
        if (pc !== 12'd0 || fv !== 1'b1 || cnt !== 16'd0) begin
            n_err++;
            $display("FAIL post_reset_run: pc=%0d fv=%0b cnt=%0d, want 0/1/0", pc, fv, cnt);
        end
        tick();
        n_cmp++;
        if (pc !== 12'd1 || cnt !== 16'd1) begin
            n_err++;
            $display("FAIL post_reset_step: pc=%0d cnt=%0d, want 1/1", pc, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_straight();
        test_handshake();
        test_jumps();
        test_stall();
        test_wrap();
        test_start_eq_end();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
